// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and jump-target helper for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_DRAIN} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP = 32'd4;
    // J/JAL target: region bits come from the PC of the instruction after the jump
    function automatic logic [31:0] jump_target(input logic [29:0] word_pc, input logic [25:0] idx);
        return {word_pc[29:26] + 4'(&word_pc[25:0]), idx, 2'b00};
    endfunction
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: synchronous FIFO of {pc, instr} entries with push/pop/clear
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clear,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    // pointers and occupancy; clear wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // storage needs no reset: an empty slot is never presented
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
    assign dout  = mem[rd_ptr];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem fetch stage feeding decode; FETCH_PERF_CNT_EN adds FetchCnt/BubbleCnt
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] RedirTgt_EX,
    input  logic        AnyStall,
    input  logic        Jump_IDM1,
    input  logic [25:0] JumpTgt_IDM1,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] FetchData_IF,
    output logic [31:0] FetchPc_IF,
    output logic        FetchValid_IF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCnt,
    output logic [31:0] BubbleCnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    fetch_state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, resp_pc, resp_pc_nxt;
    logic [CW-1:0] outstanding, outstanding_nxt, discard, discard_nxt, count;
    logic [63:0] head;
    logic full, empty, fire, resp, push, pop, jump, redirect;

    fetch_buf #(.DEPTH(BUF_DEPTH), .W(64)) u_buf (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .clear(redirect),
        .din({resp_pc, ImemRdata}),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // handshake events, capacity-gated request and next values of PC, counters and FSM
    always_comb begin
        ImemReq = (state == FS_RUN) && ({1'b0, outstanding} + {1'b0, count} < (CW+1)'(BUF_DEPTH));
        fire = ImemReq && ImemGnt;
        resp = ImemRvalid && (outstanding != '0);
        push = resp && (discard == '0);
        pop = !empty && !AnyStall;
        jump = Jump_IDM1 && pop && !flush;
        redirect = flush || jump;
        outstanding_nxt = outstanding + CW'(fire) - CW'(resp);
        discard_nxt = redirect ? outstanding_nxt : discard - CW'(resp && discard != '0);
        pc_nxt = flush ? RedirTgt_EX : jump ? jump_target(head[63:34], JumpTgt_IDM1) : fire ? pc + PC_STEP : pc;
        resp_pc_nxt = redirect ? pc_nxt : push ? resp_pc + PC_STEP : resp_pc;
        state_nxt = (state == FS_BOOT) ? FS_RUN :
                    (discard_nxt != '0 && (redirect || state == FS_DRAIN)) ? FS_DRAIN : FS_RUN;
    end

    // PC, expected response PC, in-flight/discard counters and FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_BOOT;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            resp_pc     <= resp_pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

    assign ImemAddr      = pc;
    assign FetchValid_IF = !empty;
    assign FetchData_IF  = empty ? NOP_INSTR : head[31:0];
    assign FetchPc_IF    = empty ? '0 : head[63:32];

    // the request cap keeps returned words within buffer capacity
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

`ifdef FETCH_PERF_CNT_EN
    // pops and decode-idle bubbles; flush leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCnt  <= '0;
            BubbleCnt <= '0;
        end else begin
            FetchCnt  <= FetchCnt + 32'(pop);
            BubbleCnt <= BubbleCnt + 32'(empty && !AnyStall);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a program-order stream model
module tb_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0, AnyStall = 1'b0, Jump_IDM1 = 1'b0;
    logic [31:0] RedirTgt_EX = '0;
    logic [25:0] JumpTgt_IDM1 = '0;
    logic ImemReq, ImemGnt = 1'b0, ImemRvalid = 1'b0;
    logic [31:0] ImemAddr, ImemRdata = '0;
    logic [31:0] FetchData_IF, FetchPc_IF;
    logic FetchValid_IF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCnt, BubbleCnt;
`endif

    int checks = 0, errors = 0;
    int gnt_pct = 100, rv_pct = 100;
    int pops = 0, bubbles = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .RedirTgt_EX(RedirTgt_EX),
        .AnyStall(AnyStall), .Jump_IDM1(Jump_IDM1), .JumpTgt_IDM1(JumpTgt_IDM1),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
        .FetchData_IF(FetchData_IF), .FetchPc_IF(FetchPc_IF), .FetchValid_IF(FetchValid_IF)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCnt(FetchCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // one clock: memory model responds, stream model advances, then back to the falling edge
    task automatic step();
        logic fire, pop, jmp;
        logic [31:0] a, p4;
        ImemGnt = $urandom_range(99) < gnt_pct;
        ImemRvalid = q.size() > 0 && $urandom_range(99) < rv_pct;
        ImemRdata = ImemRvalid ? word(q[0]) : 32'h0;
        fire = ImemReq && ImemGnt;
        a = ImemAddr;
        pop = FetchValid_IF && !AnyStall;
        jmp = Jump_IDM1 && pop && !flush;
        if (pop) pops++;
        if (!FetchValid_IF && !AnyStall) bubbles++;
        p4 = exp_pc + 32'd4;
        if (flush) exp_pc = RedirTgt_EX;
        else if (jmp) exp_pc = {p4[31:28], JumpTgt_IDM1, 2'b00};
        else if (pop) exp_pc = p4;
        @(posedge clk);
        if (ImemRvalid) void'(q.pop_front());
        if (fire) q.push_back(a);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; AnyStall = 1'b0; Jump_IDM1 = 1'b0;
        ImemGnt = 1'b0; ImemRvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        exp_pc = RST_PC; pops = 0; bubbles = 0;
        gnt_pct = 100; rv_pct = 100;
    endtask

    task automatic run_until_pc(input logic [31:0] pc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (FetchValid_IF && FetchPc_IF == pc) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic run_until_valid(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (FetchValid_IF) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (ImemReq !== 1'b0 || ImemAddr !== RST_PC) begin
            errors++; $display("FAIL reset_imem: req=%b addr=%h expected 0 %h", ImemReq, ImemAddr, RST_PC);
        end
        checks++;
        if (FetchValid_IF !== 1'b0 || FetchData_IF !== 32'h0 || FetchPc_IF !== 32'h0) begin
            errors++; $display("FAIL reset_fetch: valid=%b data=%h pc=%h expected 0 0 0", FetchValid_IF, FetchData_IF, FetchPc_IF);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (FetchCnt !== 32'h0 || BubbleCnt !== 32'h0) begin
            errors++; $display("FAIL reset_perf: fetch=%0d bubble=%0d expected 0 0", FetchCnt, BubbleCnt);
        end
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] req_exp;
        int first;
        do_reset();
        req_exp = RST_PC; first = -1;
        for (int i = 0; i < 16; i++) begin
            if (ImemReq) begin
                checks++;
                if (ImemAddr !== req_exp) begin
                    errors++; $display("FAIL seq_addr: addr=%h expected %h", ImemAddr, req_exp);
                end
                req_exp += 32'd4;
            end
            if (FetchValid_IF) begin
                if (first < 0) first = i;
                checks++;
                if (FetchPc_IF !== exp_pc || FetchData_IF !== word(exp_pc)) begin
                    errors++; $display("FAIL seq_head: pc=%h data=%h expected %h %h", FetchPc_IF, FetchData_IF, exp_pc, word(exp_pc));
                end
            end
            step();
        end
        checks++;
        if (first != 3) begin
            errors++; $display("FAIL seq_latency: first valid at cycle %0d expected 3", first);
        end
    endtask

    task automatic test_stall();
        logic ok;
        logic [31:0] seen [2];
        int n;
        do_reset();
        run_until_pc(32'h8, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_reach: pc 8 not presented expected presented"); end
        AnyStall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (FetchValid_IF !== 1'b1 || FetchPc_IF !== 32'h8) begin
                errors++; $display("FAIL stall_hold: valid=%b pc=%h expected 1 00000008", FetchValid_IF, FetchPc_IF);
            end
            step();
        end
        checks++;
        if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_cap: req=%b expected 0", ImemReq); end
        AnyStall = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            if (FetchValid_IF) begin seen[n] = FetchPc_IF; n++; end
            step();
        end
        checks++;
        if (n != 2 || seen[0] !== 32'h8 || seen[1] !== 32'hC) begin
            errors++; $display("FAIL stall_resume: n=%0d pcs=%h %h expected 2 00000008 0000000c", n, seen[0], seen[1]);
        end
    endtask

    task automatic test_jump();
        logic ok;
        int k, drain;
        do_reset();
        run_until_pc(32'h10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL jump_reach: pc 10 not presented expected presented"); end
        Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h40;
        step();
        Jump_IDM1 = 1'b0;
        k = q.size(); drain = 0;
        for (int i = 0; i < 20 && !FetchValid_IF; i++) begin
            if (dut.state == FS_DRAIN) drain++;
            step();
        end
        checks++;
        if (FetchValid_IF !== 1'b1 || FetchPc_IF !== 32'h100 || FetchData_IF !== word(32'h100)) begin
            errors++; $display("FAIL jump_target: valid=%b pc=%h data=%h expected 1 00000100 %h", FetchValid_IF, FetchPc_IF, FetchData_IF, word(32'h100));
        end
        checks++;
        if (drain != k) begin errors++; $display("FAIL jump_drain: drain cycles %0d expected %0d", drain, k); end
    endtask

    task automatic test_flush_jump();
        logic ok;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (FetchValid_IF && q.size() > 0) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL fj_reach: no head with word in flight expected one"); end
        flush = 1'b1; RedirTgt_EX = 32'h200; Jump_IDM1 = 1'b1; JumpTgt_IDM1 = 26'h123;
        step();
        flush = 1'b0; Jump_IDM1 = 1'b0;
        checks++;
        if (FetchValid_IF !== 1'b0) begin errors++; $display("FAIL fj_empty: valid=%b expected 0", FetchValid_IF); end
        run_until_valid(ok);
        checks++;
        if (!ok || FetchPc_IF !== 32'h200 || FetchData_IF !== word(32'h200)) begin
            errors++; $display("FAIL fj_target: pc=%h data=%h expected 00000200 %h", FetchPc_IF, FetchData_IF, word(32'h200));
        end
    endtask

    task automatic test_gnt_hold();
        logic ok;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] bc0;
`endif
        do_reset();
        repeat (6) step();
        gnt_pct = 0; flush = 1'b1; RedirTgt_EX = 32'h20;
        step();
        flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ImemReq) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL hold_reach: no request after flush expected one"); end
`ifdef FETCH_PERF_CNT_EN
        bc0 = BubbleCnt;
`endif
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ImemReq !== 1'b1 || ImemAddr !== 32'h20 || FetchValid_IF !== 1'b0 || FetchData_IF !== 32'h0) begin
                errors++; $display("FAIL hold_stable: req=%b addr=%h valid=%b data=%h expected 1 00000020 0 0", ImemReq, ImemAddr, FetchValid_IF, FetchData_IF);
            end
            step();
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (BubbleCnt - bc0 !== 32'd4) begin errors++; $display("FAIL hold_bubbles: delta=%0d expected 4", BubbleCnt - bc0); end
`endif
        gnt_pct = 100;
        run_until_valid(ok);
        checks++;
        if (!ok || FetchPc_IF !== 32'h20) begin errors++; $display("FAIL hold_resume: pc=%h expected 00000020", FetchPc_IF); end
    endtask

    task automatic test_wrap();
        logic [31:0] seen [3];
        int n;
        do_reset();
        repeat (4) step();
        flush = 1'b1; RedirTgt_EX = 32'hFFFF_FFF8;
        step();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 30 && n < 3; i++) begin
            if (FetchValid_IF) begin seen[n] = FetchPc_IF; n++; end
            step();
        end
        checks++;
        if (n != 3 || seen[0] !== 32'hFFFF_FFF8 || seen[1] !== 32'hFFFF_FFFC || seen[2] !== 32'h0) begin
            errors++; $display("FAIL wrap: n=%0d pcs=%h %h %h expected fffffff8 fffffffc 00000000", n, seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        do_reset();
        rv_pct = 0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 2) begin ok = 1'b1; break; end
            step();
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_reach: outstanding=%0d expected 2", q.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ImemReq !== 1'b0 || ImemAddr !== RST_PC || FetchValid_IF !== 1'b0 || FetchData_IF !== 32'h0 || FetchPc_IF !== 32'h0) begin
            errors++; $display("FAIL rmid_outputs: req=%b addr=%h valid=%b data=%h pc=%h expected 0 %h 0 0 0", ImemReq, ImemAddr, FetchValid_IF, FetchData_IF, FetchPc_IF, RST_PC);
        end
        @(negedge clk);
        rst_n = 1'b1; ImemGnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ImemRvalid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (FetchValid_IF !== 1'b0) begin errors++; $display("FAIL rmid_late: valid=%b expected 0", FetchValid_IF); end
        end
        ImemRvalid = 1'b0;
        q.delete(); exp_pc = RST_PC; gnt_pct = 100; rv_pct = 100;
        run_until_valid(ok);
        checks++;
        if (!ok || FetchPc_IF !== RST_PC || FetchData_IF !== word(RST_PC)) begin
            errors++; $display("FAIL rmid_restart: pc=%h data=%h expected %h %h", FetchPc_IF, FetchData_IF, RST_PC, word(RST_PC));
        end
    endtask

    task automatic test_random();
        logic hold;
        logic [31:0] hold_addr;
        do_reset();
        gnt_pct = 70; rv_pct = 60; hold = 1'b0; hold_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            AnyStall = $urandom_range(99) < 25;
            flush = $urandom_range(99) < 3;
            RedirTgt_EX = $urandom() & 32'hFFFF_FFFC;
            Jump_IDM1 = $urandom_range(99) < 8;
            JumpTgt_IDM1 = 26'($urandom());
            if (FetchValid_IF) begin
                checks++;
                if (FetchPc_IF !== exp_pc || FetchData_IF !== word(exp_pc)) begin
                    errors++; $display("FAIL rand_head: cycle %0d pc=%h data=%h expected %h %h", i, FetchPc_IF, FetchData_IF, exp_pc, word(exp_pc));
                end
            end
            if (hold) begin
                checks++;
                if (ImemReq !== 1'b1 || ImemAddr !== hold_addr) begin
                    errors++; $display("FAIL rand_req_stable: req=%b addr=%h expected 1 %h", ImemReq, ImemAddr, hold_addr);
                end
            end
            checks++;
            if (q.size() > DEPTH) begin errors++; $display("FAIL rand_cap: outstanding=%0d expected <=%0d", q.size(), DEPTH); end
            hold_addr = ImemAddr;
            hold = ImemReq && !flush && !(Jump_IDM1 && FetchValid_IF && !AnyStall);
            step();
            hold = hold && !ImemGnt;
        end
        flush = 1'b0; AnyStall = 1'b0; Jump_IDM1 = 1'b0;
        checks++;
        if (pops == 0) begin errors++; $display("FAIL rand_progress: pops=%0d expected >0", pops); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (FetchCnt !== 32'(pops) || BubbleCnt !== 32'(bubbles)) begin
            errors++; $display("FAIL rand_perf: fetch=%0d bubble=%0d expected %0d %0d", FetchCnt, BubbleCnt, pops, bubbles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump();
        test_flush_jump();
        test_gnt_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
